cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_line_ram.sv | 34 +++
 rtl/cache_ctrl.sv | 128 ++++++++++++
 tb/tb_cache_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped read cache controller:
// FSM state encoding and default geometry.
package cache_pkg;

    localparam int DEF_INDEX_LENGTH = 4;
    localparam int DEF_TAG_LENGTH   = 8;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int STATS_WIDTH      = 32;

    typedef enum logic [2:0] {
        FLUSH  = 3'd0,
        IDLE   = 3'd1,
        LOOKUP = 3'd2,
        REFILL = 3'd3,
        FILL   = 3'd4
    } state_t;

endpackage

// File: rtl/cache_line_ram.sv
// Tag + data storage for the direct-mapped cache: one entry per line,
// synchronous write, asynchronous read, no reset (valid bits live outside).
module cache_line_ram
    import cache_pkg::*;
#(
    parameter int INDEX_LENGTH = DEF_INDEX_LENGTH,
    parameter int TAG_LENGTH   = DEF_TAG_LENGTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [INDEX_LENGTH-1:0] index,
    input  logic [TAG_LENGTH-1:0]   wtag,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [TAG_LENGTH-1:0]   rtag,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int CACHE_LINES = 2 ** INDEX_LENGTH;

    logic [TAG_LENGTH-1:0] tag_mem  [CACHE_LINES];
    logic [DATA_WIDTH-1:0] data_mem [CACHE_LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[index]  <= wtag;
            data_mem[index] <= wdata;
        end
    end

    assign rtag  = tag_mem[index];
    assign rdata = data_mem[index];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped read cache controller with external valid-bit RAM.
// Optional hit/miss statistics counters enabled by CACHE_CTRL_STATS_EN.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_LENGTH = DEF_INDEX_LENGTH,
    parameter int TAG_LENGTH   = DEF_TAG_LENGTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cpu_req_i,
    input  logic [TAG_LENGTH+INDEX_LENGTH-1:0] cpu_addr_i,
    output logic                               cpu_ready_o,
    output logic                               cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0]              cpu_rdata_o,
    output logic                               cpu_hit_o,
    input  logic                               flush_i,
    output logic [INDEX_LENGTH-1:0]            vr_index_o,
    output logic                               vr_we_o,
    output logic                               vr_valid_o,
    input  logic                               vr_valid_i,
    output logic                               mem_req_o,
    output logic [TAG_LENGTH+INDEX_LENGTH-1:0] mem_addr_o,
    input  logic                               mem_ack_i,
    input  logic [DATA_WIDTH-1:0]              mem_data_i
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]             hit_cnt_o,
    output logic [STATS_WIDTH-1:0]             miss_cnt_o
`endif
);

    localparam int ADDR_W = TAG_LENGTH + INDEX_LENGTH;
    localparam logic [INDEX_LENGTH-1:0] IDX_ONE = 1;

    state_t                  state;
    logic [INDEX_LENGTH-1:0] sweep_idx;
    logic [ADDR_W-1:0]       addr_q;
    logic [INDEX_LENGTH-1:0] cap_idx;
    logic [TAG_LENGTH-1:0]   cap_tag;
    logic [TAG_LENGTH-1:0]   line_tag;
    logic [DATA_WIDTH-1:0]   line_data;
    logic                    hit;
    logic                    lookup_hit;
    logic                    rvalid;
    logic                    refill_wr;

    assign cap_idx    = addr_q[INDEX_LENGTH-1:0];
    assign cap_tag    = addr_q[ADDR_W-1:INDEX_LENGTH];
    assign hit        = vr_valid_i && (line_tag == cap_tag);
    assign lookup_hit = (state == LOOKUP) && hit;
    assign rvalid     = lookup_hit || (state == FILL);
    // Writes are gated by rst so a refill caught by reset is discarded.
    assign refill_wr  = rst && (state == REFILL) && mem_ack_i;

    cache_line_ram #(
        .INDEX_LENGTH(INDEX_LENGTH),
        .TAG_LENGTH  (TAG_LENGTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_line_ram (
        .clk  (clk),
        .we   (refill_wr),
        .index(cap_idx),
        .wtag (cap_tag),
        .wdata(mem_data_i),
        .rtag (line_tag),
        .rdata(line_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FLUSH;
            sweep_idx <= '0;
        end else begin
            case (state)
                FLUSH: begin
                    sweep_idx <= sweep_idx + IDX_ONE;
                    if (sweep_idx == '1) state <= IDLE;
                end
                IDLE: begin
                    if (flush_i)        state <= FLUSH;
                    else if (cpu_req_i) state <= LOOKUP;
                end
                LOOKUP:  state <= hit ? IDLE : REFILL;
                REFILL:  if (mem_ack_i) state <= FILL;
                FILL:    state <= IDLE;
                default: state <= FLUSH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && !flush_i && cpu_req_i) addr_q <= cpu_addr_i;
    end

    always_comb begin
        cpu_ready_o  = (state == IDLE) && !flush_i;
        cpu_hit_o    = lookup_hit;
        cpu_rvalid_o = rvalid;
        cpu_rdata_o  = rvalid ? line_data : '0;
        // The sweep counter owns the valid RAM only while flushing.
        vr_index_o   = (state == FLUSH) ? sweep_idx : cap_idx;
        vr_we_o      = (rst && (state == FLUSH)) || refill_wr;
        vr_valid_o   = refill_wr;
        mem_req_o    = (state == REFILL);
        mem_addr_o   = addr_q;
    end

`ifdef CACHE_CTRL_STATS_EN
    localparam logic [STATS_WIDTH-1:0] STAT_ONE = 1;

    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || (state == IDLE && flush_i)) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state == LOOKUP) begin
            if (hit) hit_cnt_o  <= sat_inc(hit_cnt_o);
            else     miss_cnt_o <= sat_inc(miss_cnt_o);
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized bench for cache_ctrl against an array-based cache model;
// stats counters are checked when CACHE_CTRL_STATS_EN is defined.
module tb_cache_ctrl;

    localparam int IL    = 4;
    localparam int TL    = 8;
    localparam int DW    = 32;
    localparam int LINES = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req_i;
    logic [11:0]   cpu_addr_i;
    logic          cpu_ready_o;
    logic          cpu_rvalid_o;
    logic [DW-1:0] cpu_rdata_o;
    logic          cpu_hit_o;
    logic          flush_i;
    logic [IL-1:0] vr_index_o;
    logic          vr_we_o;
    logic          vr_valid_o;
    logic          vr_valid_i;
    logic          mem_req_o;
    logic [11:0]   mem_addr_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_data_i;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0]   hit_cnt_o;
    logic [31:0]   miss_cnt_o;
`endif

    always #5 clk = ~clk;

    cache_ctrl #(.INDEX_LENGTH(IL), .TAG_LENGTH(TL), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_ready_o(cpu_ready_o),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o), .cpu_hit_o(cpu_hit_o),
        .flush_i(flush_i),
        .vr_index_o(vr_index_o), .vr_we_o(vr_we_o), .vr_valid_o(vr_valid_o), .vr_valid_i(vr_valid_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    // External valid RAM; starts all-ones so only the sweep can clear it.
    logic vr_mem [LINES] = '{default: 1'b1};
    assign vr_valid_i = vr_mem[vr_index_o];
    always @(posedge clk) if (vr_we_o) vr_mem[vr_index_o] <= vr_valid_o;

    // Reference model: the cache contents as the CPU should see them.
    bit          m_valid [LINES];
    logic [7:0]  m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] m_hits, m_misses;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = '0;
        m_misses = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_CTRL_STATS_EN
        check({tag, "_hits"}, hit_cnt_o, m_hits);
        check({tag, "_misses"}, miss_cnt_o, m_misses);
`endif
    endtask

    // Expects the full sweep starting this cycle, then a ready IDLE cycle.
    task automatic expect_sweep();
        for (int i = 0; i < LINES; i++) begin
            cyc();
            rst        = 1'b1;
            flush_i    = 1'b0;
            cpu_req_i  = 1'($urandom_range(0, 1));
            cpu_addr_i = 12'($urandom);
            mem_ack_i  = 1'($urandom_range(0, 1));
            mem_data_i = $urandom;
            @(negedge clk);
            check("sweep_we", 32'(vr_we_o), 32'd1);
            check("sweep_valid", 32'(vr_valid_o), 32'd0);
            check("sweep_index", 32'(vr_index_o), 32'(i));
            check("sweep_ready", 32'(cpu_ready_o), 32'd0);
            check("sweep_rvalid", 32'(cpu_rvalid_o), 32'd0);
            check("sweep_mem_req", 32'(mem_req_o), 32'd0);
        end
        cyc();
        cpu_req_i = 1'b0;
        mem_ack_i = 1'b0;
        @(negedge clk);
        check("post_sweep_ready", 32'(cpu_ready_o), 32'd1);
        check("post_sweep_we", 32'(vr_we_o), 32'd0);
        check_stats("post_sweep");
    endtask

    task automatic do_flush();
        cyc();
        flush_i   = 1'b1;
        cpu_req_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("flush_ready_low", 32'(cpu_ready_o), 32'd0);
        model_clear();
        expect_sweep();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            cpu_req_i  = 1'b0;
            mem_ack_i  = 1'($urandom_range(0, 1));
            mem_data_i = $urandom;
            @(negedge clk);
            check("idle_ready", 32'(cpu_ready_o), 32'd1);
            check("idle_rvalid", 32'(cpu_rvalid_o), 32'd0);
            check("idle_we", 32'(vr_we_o), 32'd0);
            check("idle_mem_req", 32'(mem_req_o), 32'd0);
            check_stats("idle");
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [31:0] fdata,
                           input int delay, input bit flush_mid);
        int   idx;
        logic [7:0] tg;
        bit   exp_hit;
        int   waitc;
        idx = int'(addr[3:0]);
        tg  = addr[11:4];
        cyc();
        cpu_req_i  = 1'b1;
        cpu_addr_i = addr;
        mem_ack_i  = 1'b0;
        flush_i    = 1'b0;
        @(negedge clk);
        waitc = 0;
        while (!cpu_ready_o && waitc < 40) begin
            cyc();
            @(negedge clk);
            waitc++;
        end
        check("accept_ready", 32'(cpu_ready_o), 32'd1);
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        // Lookup cycle: junk on the bus and a stray ack must not matter.
        cyc();
        cpu_req_i  = 1'($urandom_range(0, 1));
        cpu_addr_i = 12'($urandom);
        mem_ack_i  = 1'($urandom_range(0, 1));
        mem_data_i = $urandom;
        @(negedge clk);
        check("lookup_index", 32'(vr_index_o), 32'(idx));
        check("lookup_rvalid", 32'(cpu_rvalid_o), 32'(exp_hit));
        check("lookup_hit", 32'(cpu_hit_o), 32'(exp_hit));
        check("lookup_we", 32'(vr_we_o), 32'd0);
        check("lookup_mem_req", 32'(mem_req_o), 32'd0);
        if (exp_hit) begin
            check("hit_data", cpu_rdata_o, m_data[idx]);
            m_hits = sat(m_hits);
        end else begin
            m_misses = sat(m_misses);
            for (int d = 0; d <= delay; d++) begin
                cyc();
                cpu_req_i  = 1'($urandom_range(0, 1));
                cpu_addr_i = 12'($urandom);
                mem_ack_i  = (d == delay);
                mem_data_i = (d == delay) ? fdata : $urandom;
                if (flush_mid) flush_i = 1'b1;
                @(negedge clk);
                check("refill_req", 32'(mem_req_o), 32'd1);
                check("refill_addr", 32'(mem_addr_o), 32'(addr));
                check("refill_rvalid", 32'(cpu_rvalid_o), 32'd0);
                check("refill_we", 32'(vr_we_o), 32'(d == delay));
                if (d == delay) begin
                    check("refill_vr_valid", 32'(vr_valid_o), 32'd1);
                    check("refill_vr_index", 32'(vr_index_o), 32'(idx));
                end
            end
            cyc();
            mem_ack_i  = 1'($urandom_range(0, 1));
            mem_data_i = $urandom;
            @(negedge clk);
            check("fill_rvalid", 32'(cpu_rvalid_o), 32'd1);
            check("fill_hit", 32'(cpu_hit_o), 32'd0);
            check("fill_data", cpu_rdata_o, fdata);
            check("fill_mem_req", 32'(mem_req_o), 32'd0);
            check("fill_we", 32'(vr_we_o), 32'd0);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = fdata;
        end
        cpu_req_i = 1'b0;
        mem_ack_i = 1'b0;
    endtask

    logic [7:0] tpool [4];

    initial begin
        tpool = '{8'h3A, 8'h4A, 8'h00, 8'hFF};
        rst = 1'b0; cpu_req_i = 1'b0; cpu_addr_i = '0; flush_i = 1'b0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        for (int i = 0; i < LINES; i++) begin
            m_tag[i]  = '0;
            m_data[i] = '0;
        end
        model_clear();

        for (int i = 0; i < 3; i++) begin
            cyc();
            rst       = 1'b0;
            cpu_req_i = 1'b1;
            mem_ack_i = 1'b1;
            @(negedge clk);
        end
        check("rst_ready", 32'(cpu_ready_o), 32'd0);
        check("rst_rvalid", 32'(cpu_rvalid_o), 32'd0);
        check("rst_hit", 32'(cpu_hit_o), 32'd0);
        check("rst_rdata", cpu_rdata_o, 32'd0);
        check("rst_we", 32'(vr_we_o), 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        expect_sweep();

        // Directed scenarios: miss/fill, hit, conflict eviction, flush during refill.
        do_read(12'h3A5, 32'hDEADBEEF, 1, 1'b0);
        idle(1);
        do_read(12'h3A5, 32'h0, 0, 1'b0);
        idle(1);
        do_read(12'h4A5, 32'h12345678, 0, 1'b0);
        do_read(12'h3A5, 32'hCAFEF00D, 2, 1'b0);
        do_read(12'h4A5, 32'h0BADF00D, 2, 1'b1);
        do_flush();
        do_read(12'h4A5, 32'h13572468, 0, 1'b0);
        idle(1);

        // Reset two cycles into a refill; the late ack must be discarded.
        cyc(); cpu_req_i = 1'b1; cpu_addr_i = 12'h5C7;
        @(negedge clk);
        check("r_rst_accept", 32'(cpu_ready_o), 32'd1);
        cyc(); cpu_req_i = 1'b0;
        @(negedge clk);
        check("r_rst_lookup_rvalid", 32'(cpu_rvalid_o), 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            @(negedge clk);
            check("r_rst_refill_req", 32'(mem_req_o), 32'd1);
        end
        cyc(); rst = 1'b0; mem_ack_i = 1'b1; mem_data_i = 32'hBAD0BAD0;
        @(negedge clk);
        check("r_rst_no_write", 32'(vr_we_o), 32'd0);
        cyc();
        @(negedge clk);
        check("r_rst_req_drop", 32'(mem_req_o), 32'd0);
        check("r_rst_rvalid", 32'(cpu_rvalid_o), 32'd0);
        check("r_rst_ready", 32'(cpu_ready_o), 32'd0);
        model_clear();
        expect_sweep();
        do_read(12'h5C7, 32'h600DCAFE, 1, 1'b0);
        do_read(12'h5C7, 32'h0, 0, 1'b0);

        // Random traffic over a few indices and tags to mix hits and misses.
        for (int t = 0; t < 60; t++) begin
            int r;
            logic [11:0] a;
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                do_flush();
            end else begin
                a = {tpool[$urandom_range(0, 3)], 4'($urandom_range(0, 3))};
                do_read(a, $urandom, int'($urandom_range(0, 3)), r == 1);
                if (r == 1) do_flush();
            end
            idle(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "timeout");
    end

endmodule
